// File: rtl/reversal_msg_ram_if.sv
// Bundle of capture, read and status signals for reversal_msg_ram.
// ADDR_W must match the attached reversal_msg_ram instance.
interface reversal_msg_ram_if #(
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_bit;
  logic              clear;
  logic              rev_mode;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data;
  logic [4:0]        count;
  logic              full;
  logic              overflow;

  modport master (
    output in_valid, in_bit, clear, rev_mode, addr,
    input  data, count, full, overflow
  );

  modport slave (
    input  in_valid, in_bit, clear, rev_mode, addr,
    output data, count, full, overflow
  );
endinterface

// File: rtl/reversal_msg_ram.sv
// Captures a bit message as ASCII "0"/"1" and reads it back, optionally reversed.
// Optional overflow detection is built only when REV_MSG_OVERFLOW_EN is defined.
module reversal_msg_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 5
) (
  input logic             clk,
  input logic             rst,
  reversal_msg_ram_if.slave bus
);
  typedef enum logic [1:0] {
    S_EMPTY,
    S_FILLING,
    S_FULL
  } state_t;

  localparam logic [4:0]        LP_LAST = 5'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] LP_NL   = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] LP_CR   = ADDR_W'(WIDTH + 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_count;
  logic [7:0] r_slot [WIDTH];
  logic [7:0] r_data;
  logic [7:0] w_rd;
  logic [7:0] w_char;
  logic       w_wr_en;
  logic       w_full;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // next-state: clear wins, FULL is absorbing until clear/rst
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = S_EMPTY;
    end else begin
      unique case (r_state)
        S_EMPTY, S_FILLING: begin
          if (bus.in_valid)
            w_state_nxt = (r_count == LP_LAST) ? S_FULL : S_FILLING;
        end
        S_FULL:  w_state_nxt = S_FULL;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // state outputs: write enable and full flag
  always_comb begin
    w_full  = (r_state == S_FULL);
    w_wr_en = bus.in_valid & ~bus.clear & ~w_full;
    w_char  = bus.in_bit ? 8'h31 : 8'h30;
  end

  // capture counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_count <= '0;
    else if (bus.clear) r_count <= '0;
    else if (w_wr_en) r_count <= r_count + 5'd1;
  end

  // slot storage, written at the current count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < WIDTH; k++) r_slot[k] <= 8'h30;
    end else if (bus.clear) begin
      for (int k = 0; k < WIDTH; k++) r_slot[k] <= 8'h30;
    end else if (w_wr_en) begin
      for (int k = 0; k < WIDTH; k++)
        if (r_count == 5'(k)) r_slot[k] <= w_char;
    end
  end

  // read mux: slots (direct or mirrored), then CR/LF, else space
  always_comb begin
    w_rd = 8'h20;
    if (bus.addr == LP_NL) w_rd = 8'h0A;
    else if (bus.addr == LP_CR) w_rd = 8'h0D;
    for (int k = 0; k < WIDTH; k++) begin
      if (bus.rev_mode) begin
        if (bus.addr == ADDR_W'(WIDTH - 1 - k)) w_rd = r_slot[k];
      end else begin
        if (bus.addr == ADDR_W'(k)) w_rd = r_slot[k];
      end
    end
  end

  // registered read port, sees pre-write slot contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_data <= 8'h00;
    else     r_data <= w_rd;
  end

  assign bus.data  = r_data;
  assign bus.count = r_count;
  assign bus.full  = w_full;

`ifdef REV_MSG_OVERFLOW_EN
  logic r_overflow;

  // sticky overflow on capture attempt while full
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_overflow <= 1'b0;
    else if (bus.clear)              r_overflow <= 1'b0;
    else if (bus.in_valid && w_full) r_overflow <= 1'b1;
  end

  assign bus.overflow = r_overflow;
`else
  assign bus.overflow = 1'b0;
`endif
endmodule

// File: tb/tb_reversal_msg_ram.sv
// Randomized and directed bench for reversal_msg_ram.
// Reference model keeps the captured message as a queue of bits.
module tb_reversal_msg_ram;
  localparam int W  = 8;
  localparam int AW = 5;
`ifdef REV_MSG_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reversal_msg_ram_if #(.ADDR_W(AW)) bi ();
  reversal_msg_ram_if #(.ADDR_W(2))  b1 ();

  reversal_msg_ram #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .bus(bi)
  );
  reversal_msg_ram #(.WIDTH(1), .ADDR_W(2)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  int checks = 0;
  int errors = 0;
  bit msg[$];
  bit ovf = 1'b0;
  logic [7:0] exp1 [4];
  bit cap[8];

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_char(int a, bit r);
    int idx;
    if (a < W) begin
      idx = r ? (W - 1 - a) : a;
      if (idx < msg.size()) return msg[idx] ? 8'h31 : 8'h30;
      return 8'h30;
    end
    if (a == W) return 8'h0A;
    if (a == W + 1) return 8'h0D;
    return 8'h20;
  endfunction

  task automatic model_edge(bit v, bit b, bit c);
    if (c) begin
      msg.delete();
      ovf = 1'b0;
    end else if (v) begin
      if (msg.size() < W) msg.push_back(b);
      else if (OVF_EN) ovf = 1'b1;
    end
  endtask

  task automatic cyc(bit v, bit b, bit c, bit r, int a);
    logic [7:0] e;
    bi.in_valid = v;
    bi.in_bit   = b;
    bi.clear    = c;
    bi.rev_mode = r;
    bi.addr     = AW'(a);
    e = ref_char(a, r);
    @(posedge clk);
    #1;
    model_edge(v, b, c);
    chk("data", bi.data, e);
    chk("count", {3'b0, bi.count}, 8'(msg.size()));
    chk("full", {7'b0, bi.full}, {7'b0, msg.size() == W});
    chk("overflow", {7'b0, bi.overflow}, {7'b0, ovf});
    bi.in_valid = 1'b0;
    bi.clear    = 1'b0;
  endtask

  task automatic sweep(bit r, int hi);
    for (int a = 0; a <= hi; a++) cyc(1'b0, 1'b0, 1'b0, r, a);
  endtask

  initial begin
    bi.in_valid = 0; bi.in_bit = 0; bi.clear = 0;
    bi.rev_mode = 0; bi.addr = '0;
    b1.in_valid = 0; b1.in_bit = 0; b1.clear = 0;
    b1.rev_mode = 0; b1.addr = '0;
    exp1 = '{8'h31, 8'h0A, 8'h0D, 8'h20};
    cap  = '{1, 1, 0, 0, 1, 0, 1, 0};

    #2;
    chk("rst_data", bi.data, 8'h00);
    chk("rst_count", {3'b0, bi.count}, 8'h00);
    chk("rst_full", {7'b0, bi.full}, 8'h00);
    chk("rst_ovf", {7'b0, bi.overflow}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // single-slot instance
    b1.in_valid = 1'b1;
    b1.in_bit   = 1'b1;
    @(posedge clk);
    #1;
    b1.in_valid = 1'b0;
    chk("w1_full", {7'b0, b1.full}, 8'h01);
    chk("w1_count", {3'b0, b1.count}, 8'h01);
    for (int a = 0; a < 4; a++) begin
      b1.addr = 2'(a);
      @(posedge clk);
      #1;
      chk("w1_data", b1.data, exp1[a]);
    end

    // directed message, reversed and direct readback
    for (int i = 0; i < W; i++) cyc(1'b1, cap[i], 1'b0, 1'b1, i);
    sweep(1'b1, 10);
    sweep(1'b0, 7);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 2);

    // capture while full
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 0);
    sweep(1'b0, 9);

    // clear beats a simultaneous capture
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, i);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 0);
    sweep(1'b0, 7);
    sweep(1'b1, 7);

    // randomized traffic
    for (int i = 0; i < 120; i++)
      cyc(1'(($urandom() >> 3) & 1), 1'($urandom_range(0, 1)),
          $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 12)));

    // asynchronous reset mid-capture
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, i);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", {3'b0, bi.count}, 8'h00);
    chk("arst_data", bi.data, 8'h00);
    chk("arst_full", {7'b0, bi.full}, 8'h00);
    msg.delete();
    ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W; i++)
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 12)));
    sweep(1'b0, 11);
    sweep(1'b1, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reversal_msg_ram.md
REVERSAL_MSG_RAM -- requirements
Module: reversal_msg_ram

Interface
REQ-001 Parameter WIDTH, default 8, number of captured bits/characters; legal range 1..16.
REQ-002 Parameter ADDR_W, default 5, read address width; SHALL satisfy 2^ADDR_W >= WIDTH+2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  capture strobe; one bit captured per high cycle.
REQ-006 in_bit  input  1  bit value captured when in_valid=1.
REQ-007 clear  input  1  synchronous restart of capture; contents reloaded to reset values.
REQ-008 rev_mode  input  1  1 = read message bit-reversed, 0 = read in capture order.
REQ-009 addr  input  ADDR_W  read character index.
REQ-010 data  output  8  registered ASCII character selected by addr.
REQ-011 count  output  5  number of characters captured, 0..WIDTH.
REQ-012 full  output  1  high when count == WIDTH.
REQ-013 overflow  output  1  sticky flag: capture attempted while full.

Function
REQ-014 Storage SHALL be WIDTH slots of 8 bits; slot k holds the ASCII character of the k-th captured bit.
REQ-015 Capture state machine SHALL have states EMPTY (count=0), FILLING (0<count<WIDTH), FULL (count=WIDTH).
REQ-016 EMPTY/FILLING with in_valid=1 SHALL write "1" (8'h31) if in_bit=1, else "0" (8'h30), into slot[count] and increment count the same edge.
REQ-017 Transition to FULL SHALL occur on the edge that writes slot[WIDTH-1]; full SHALL be high from the next cycle.
REQ-018 In FULL, in_valid=1 SHALL NOT modify any slot or count.
REQ-019 clear=1 SHALL, on the next edge, set count=0, state EMPTY, all slots to "0", overflow=0; clear SHALL win over a simultaneous in_valid.
REQ-020 in_valid=0 SHALL hold all slots and count unchanged.
REQ-021 Read mapping for addr < WIDTH: rev_mode=1 selects slot[WIDTH-1-addr]; rev_mode=0 selects slot[addr].
REQ-022 addr == WIDTH SHALL select "\n" (8'h0A); addr == WIDTH+1 SHALL select "\r" (8'h0D); any larger addr SHALL select " " (8'h20).
REQ-023 data SHALL be registered: value reflects addr, rev_mode and slot contents sampled at edge N, visible after edge N (1-cycle latency).
REQ-024 A write and a read of the same slot in one cycle SHALL return the pre-write content (read-before-write).
REQ-025 Unwritten slots SHALL read "0" (reset/clear content).
REQ-026 rev_mode MAY change any cycle; it SHALL only affect the read mux, never stored contents.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force: all slots 8'h30, count=0, full=0, overflow=0, data=8'h00, state EMPTY.
REQ-028 rst asserted mid-capture SHALL discard the partial message; capture restarts at slot 0 after release.
REQ-029 First capture after rst release SHALL be accepted on the first rising edge with in_valid=1.

Configuration
REQ-030 Macro REV_MSG_OVERFLOW_EN SHALL control overflow detection.
REQ-031 With REV_MSG_OVERFLOW_EN defined: overflow SHALL set on the edge where in_valid=1 while full=1 and hold until rst or clear.
REQ-032 Without REV_MSG_OVERFLOW_EN: overflow SHALL be constant 0 and no overflow register SHALL be built; all other behaviour unchanged.

Verification
REQ-033 WIDTH=8, capture 1,1,0,0,1,0,1,0, rev_mode=1, sweep addr 0..10 -> data "0","1","0","1","0","0","1","1","\n","\r"," ", each one cycle after addr; full=1, count=8.
REQ-034 Same capture, rev_mode=0, addr 0..7 -> "1","1","0","0","1","0","1","0"; toggling rev_mode alone changes data next cycle only.
REQ-035 After FULL, pulse in_valid with in_bit=0 -> slots unchanged; overflow=1 with REV_MSG_OVERFLOW_EN, 0 without.
REQ-036 Capture 3 bits, assert clear together with in_valid -> count=0, full=0, overflow=0, all addr 0..7 read "0".
REQ-037 Assert rst asynchronously mid-cycle after 5 captures -> count=0, data=8'h00 before next edge; subsequent 8 captures read back correctly.
REQ-038 WIDTH=1, ADDR_W=2, capture 1 -> addr 0 "1", addr 1 "\n", addr 2 "\r", addr 3 " ", full=1 after one capture.
